uart_rx: RTL and testbench

- Serial receiver for the custom UART FSM path. Its peer is the transmitter in the same FSM directory.
- Recovers 8N1 frames from the `rx` line: idle high, one low start bit, 8 data bits LSB first, one high stop bit.
- Oversampled at `CLKS_PER_BIT` clocks per bit with mid-bit sampling.
- Presents each received byte on a parallel bus with a one-cycle `valid` strobe, and reports framing errors.

---
 rtl/uart_rx.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 serial receiver. The rx line is synchronised, a start edge
//               is qualified at mid start bit, then eight data bits (LSB first)
//               and the stop bit are sampled at mid-bit. A good frame updates
//               data with a one-cycle valid strobe; a low stop bit gives a
//               one-cycle frame_err strobe and waits for the line to go idle.
//               Optional build macro UART_RX_MAJORITY_EN: each sample point
//               uses a 2-of-3 majority of the synchronised line over the
//               sample cycle and the two cycles before it.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       bussy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_START_BIT  = 3'd1;
    localparam logic [2:0] c_DATA_BITS  = 3'd2;
    localparam logic [2:0] c_STOP_BIT   = 3'd3;
    localparam logic [2:0] c_BREAK_WAIT = 3'd4;

    // Mid start bit is reached half a bit after the detected falling edge;
    // every later sample is one full bit after the previous one.
    localparam logic [7:0] c_HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] c_BIT_M1  = 8'(CLKS_PER_BIT - 1);

    // Reject illegal configurations at elaboration time.
    if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT > 255)) begin : g_bad_clks_per_bit
        $error("uart_rx: CLKS_PER_BIT must be in 4..255");
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 3)) begin : g_bad_sync_stages
        $error("uart_rx: SYNC_STAGES must be in 2..3");
    end

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic                   w_sample;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_bit_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_frame_err;

    logic       w_hit_half;
    logic       w_hit_bit;
    logic       w_cnt_clr;

    // ------------------------------------------------------------------------
    // Synchroniser: presets to idle-high so reset never looks like a start bit.
    // ------------------------------------------------------------------------
    // Shift the asynchronous rx line through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Sample value used at the start, data and stop sample points.
    // ------------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Keep the two previous synchronised values for the majority vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_sample = (w_rx_s & r_hist[0]) | (w_rx_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
    assign w_sample = w_rx_s;
`endif

    // ------------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------------
    assign w_hit_half = (r_bit_cnt == c_HALF_M1);
    assign w_hit_bit  = (r_bit_cnt == c_BIT_M1);

    // Next-state decode; all decisions come from the synchronised line.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = c_START_BIT;
                end
            end
            c_START_BIT: begin
                if (w_hit_half) begin
                    // A high mid-start sample is a glitch, not a frame.
                    w_state_nxt = w_sample ? c_IDLE : c_DATA_BITS;
                end
            end
            c_DATA_BITS: begin
                if (w_hit_bit && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = c_STOP_BIT;
                end
            end
            c_STOP_BIT: begin
                if (w_hit_bit) begin
                    w_state_nxt = w_sample ? c_IDLE : c_BREAK_WAIT;
                end
            end
            c_BREAK_WAIT: begin
                // Hold off until the line returns high so a break yields only
                // a single frame error.
                if (w_rx_s) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // The bit counter restarts on every state change and on every data-bit
    // boundary; it is parked at zero while waiting for the line.
    assign w_cnt_clr = (w_state_nxt != r_state)
                     || ((r_state == c_DATA_BITS) && w_hit_bit)
                     || (r_state == c_IDLE)
                     || (r_state == c_BREAK_WAIT);

    // State register and per-bit clock counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_bit_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr) begin
                r_bit_cnt <= 8'd0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 8'd1;
            end
        end
    end

    // Data-bit index and shift register; first bit received ends up in [0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if ((r_state == c_START_BIT) && (w_state_nxt == c_DATA_BITS)) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == c_DATA_BITS) && w_hit_bit) begin
                r_shift   <= {w_sample, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // Registered outputs: strobes are single-cycle, data holds the last good byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            if ((r_state == c_STOP_BIT) && w_hit_bit) begin
                if (w_sample) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign bussy     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (CLKS_PER_BIT=16,
//               SYNC_STAGES=2). Frames are driven bit by bit on rx; a negedge
//               monitor counts valid / frame_err strobes and records bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       bussy;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .bussy    (bussy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Strobe monitor
    // ------------------------------------------------------------------------
    int         n_valid   = 0;
    int         n_ferr    = 0;
    int         n_both    = 0;
    int         n_consec  = 0;
    int         valid_cyc = 0;
    logic [7:0] last_byte = 8'h00;
    logic       prev_v    = 1'b0;
    logic       prev_f    = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                n_valid++;
                last_byte = data;
                valid_cyc = cyc;
            end
            if (frame_err) n_ferr++;
            if (valid && frame_err) n_both++;
            if ((prev_v && valid) || (prev_f && frame_err)) n_consec++;
            prev_v = valid;
            prev_f = frame_err;
        end else begin
            prev_v = 1'b0;
            prev_f = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int         c0;
        int         v0;
        int         f0;
        logic [7:0] exp_spike;

        // Reset held, line toggling.
        rst_n = 1'b0;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            rx = ~rx;
            tick(2);
        end
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_bussy", bussy, 1'b0);
        rx = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2 * CPB);
        check("idle_bussy", bussy, 1'b0);
        check("idle_no_valid", n_valid, 0);

        // Single frame and latency from the start edge.
        c0 = cyc;
        send_byte(8'hA5, 1'b1);
        tick(2 * CPB);
        check("a5_count", n_valid, 1);
        check("a5_data", data, 8'hA5);
        check("a5_latency", valid_cyc - c0, 9 * CPB + HALF + 3);
        check("a5_no_ferr", n_ferr, 0);
        check("a5_bussy", bussy, 1'b0);

        // Back-to-back frames, no idle gap.
        v0 = n_valid;
        send_byte(8'h00, 1'b1);
        tick(1);
        check("b2b_0", last_byte, 8'h00);
        send_byte(8'hFF, 1'b1);
        check("b2b_1", last_byte, 8'hFF);
        send_byte(8'h3C, 1'b1);
        tick(2 * CPB);
        check("b2b_2", last_byte, 8'h3C);
        check("b2b_count", n_valid - v0, 3);

        // Start-bit glitch, then a clean frame.
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2 * CPB);
        check("glitch_no_valid", n_valid - v0, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);
        check("glitch_bussy", bussy, 1'b0);
        send_byte(8'h5A, 1'b1);
        tick(2 * CPB);
        check("5a_data", data, 8'h5A);
        check("5a_count", n_valid - v0, 1);

        // Framing error followed by a long break.
        v0 = n_valid;
        f0 = n_ferr;
        send_byte(8'h81, 1'b0);
        rx = 1'b0;
        tick(40 * CPB);
        check("brk_bussy", bussy, 1'b1);
        rx = 1'b1;
        tick(2 * CPB);
        check("brk_one_ferr", n_ferr - f0, 1);
        check("brk_no_valid", n_valid - v0, 0);
        check("brk_data_held", data, 8'h5A);
        send_byte(8'h42, 1'b1);
        tick(2 * CPB);
        check("42_data", data, 8'h42);
        check("42_count", n_valid - v0, 1);

        // Reset after the 4th data bit of 8'hF0, then 8'h0F.
        v0 = n_valid;
        f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(5);
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_bussy", bussy, 1'b0);
        rst_n = 1'b1;
        tick(CPB);
        send_byte(8'h0F, 1'b1);
        tick(2 * CPB);
        check("0f_count", n_valid - v0, 1);
        check("0f_data", last_byte, 8'h0F);
        check("0f_no_ferr", n_ferr - f0, 0);

        // 1-clk low spike at each data-bit sample point of 8'hFF.
        v0 = n_valid;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            rx = 1'b1;
            tick(HALF);
            rx = 1'b0;
            tick(1);
            rx = 1'b1;
            tick(CPB - HALF - 1);
        end
        send_bit(1'b1);
        tick(2 * CPB);
`ifdef UART_RX_MAJORITY_EN
        exp_spike = 8'hFF;
`else
        exp_spike = 8'h00;
`endif
        check("spike_count", n_valid - v0, 1);
        check("spike_data", data, exp_spike);

        // Strobe invariants over the whole run.
        check("never_both", n_both, 0);
        check("never_consec", n_consec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
